uart_tx_fifo: RTL and testbench

//  Parametrised RS-232 transmitter: next generation of the fixed 8N2 serial TX.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity selectors, transmitter state encoding and the bit-period helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Nearest-integer clocks per bit, rounding half up.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock write FIFO with occupancy count and a registered not-full flag.
// The head word is read straight from the array so a word written at one edge can be
// popped at the very next edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             ready_q;
    logic             ready_d;
    logic             push;
    logic             pop;

    // Handshake qualification and next occupancy; ready is precomputed from the next level.
    always_comb begin
        push    = wr_valid && ready_q;
        pop     = rd_en && (level_q != '0);
        level_d = level_q + LW'(push) - LW'(pop);
        ready_d = (level_d != LW'(DEPTH));
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy and ready flag; ready stays low throughout reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            ready_q <= ready_d;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign wr_ready = ready_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered RS-232 transmitter with configurable data width, parity and stop
// bits. Frames run back to back with no idle gap while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 781250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: bit period below 2 clocks");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    tx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 txd_q;
    logic                 done_q;

    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;
    logic                 par_bit;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (s_data),
        .wr_valid (s_valid),
        .wr_ready (s_ready),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Bit boundary, last stop bit and pop request (from idle, or chained off the final stop bit).
    always_comb begin
        bit_end   = (cnt_q == CNT_W'(DIV - 1));
        last_stop = (state_q == ST_STOP) && (bit_q == 4'(STOP_BITS - 1));
        pop       = !fifo_empty && ((state_q == ST_IDLE) || (last_stop && bit_end));
        par_bit   = (PARITY == PARITY_ODD) ? ~^fifo_data : ^fifo_data;
    end

    // Frame sequencer: divider, shifter, registered txd and tx_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            // Raised one clock early so it is high during the final clock of the last stop bit.
            done_q <= last_stop && (cnt_q == CNT_W'(DIV - 2));
            if (state_q != ST_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            if (pop) begin
                state_q <= ST_START;
                cnt_q   <= '0;
                bit_q   <= '0;
                shift_q <= fifo_data;
                par_q   <= par_bit;
                txd_q   <= 1'b0;
            end else if (bit_end) begin
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                    end
                    ST_DATA: begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        txd_q   <= 1'b1;
                        bit_q   <= '0;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd     = txd_q;
    assign tx_done = done_q;
    assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitters (8N1, 8E1, 8O2, DIV=8). Stimulus pushes the expected
// serial frame into a per-instance queue; a monitor per instance checks every clock of each frame.
module tb_uart_tx_fifo;

    localparam int CLK_HZ  = 8000000;
    localparam int BAUD_HZ = 1000000;
    localparam int DIV     = 8;

    // bits[0] is the start bit, in transmission order.
    typedef struct {
        logic [12:0] bits;
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         last_push_cyc = 0;

    logic [7:0] sd        [3];
    logic       sv        [3];
    logic       s_ready_w [3];
    logic       txd_w     [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic [4:0] level_w   [3];

    frame_t q0[$];
    frame_t q1[$];
    frame_t q2[$];
    int     start_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_HZ), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_8n1 (
        .clk(clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(s_ready_w[0]),
        .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .fifo_level(level_w[0]));

    uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_HZ), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_8e1 (
        .clk(clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(s_ready_w[1]),
        .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .fifo_level(level_w[1]));

    uart_tx_fifo #(.CLK_FREQ(CLK_HZ), .BAUD(BAUD_HZ), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut_8o2 (
        .clk(clk), .rst(rst), .s_data(sd[2]), .s_valid(sv[2]), .s_ready(s_ready_w[2]),
        .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .fifo_level(level_w[2]));

    function automatic frame_t mk(input logic [12:0] b, input int n);
        frame_t f;
        f.bits  = b;
        f.nbits = n;
        return f;
    endfunction

    // 8N1 framing: start 0, data LSB first, one stop 1.
    function automatic frame_t f8n1(input logic [7:0] d);
        return mk({3'b000, 1'b1, d, 1'b0}, 10);
    endfunction

    task automatic exp_push(input int idx, input frame_t f);
        case (idx)
            0: q0.push_back(f);
            1: q1.push_back(f);
            default: q2.push_back(f);
        endcase
    endtask

    function automatic int exp_size(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic frame_t exp_pop(input int idx);
        case (idx)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int idx, input logic [7:0] d, input frame_t f);
        int waited;
        waited  = 0;
        sd[idx] = d;
        sv[idx] = 1'b1;
        @(negedge clk);
        while (!s_ready_w[idx] && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready_w[idx]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push timeout idx=%0d data=%02h: s_ready stayed %b, expected 1", idx, d, s_ready_w[idx]);
            #1 sv[idx] = 1'b0;
        end else begin
            @(posedge clk);
            exp_push(idx, f);
            #1 sv[idx] = 1'b0;
            last_push_cyc = cyc;
            $display("push idx=%0d data=%02h cyc=%0d", idx, d, cyc);
        end
    endtask

    task automatic wait_low(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (txd_w[idx] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (txd_w[idx] !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start bit timeout idx=%0d: txd=%b, expected 0", idx, txd_w[idx]);
        end
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_size(idx) == 0 && busy_w[idx] === 1'b0 && level_w[idx] === 5'd0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("drain idx=%0d pending frames", idx), exp_size(idx), 0);
    endtask

    task automatic monitor(input int idx);
        frame_t f;
        int     total;
        int     bad;
        int     bad_k;
        logic   bad_txd, bad_done, bad_busy, exp_b, exp_d;
        bit     aborted;
        int     t0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd_w[idx] === 1'b0) begin
                if (exp_size(idx) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame idx=%0d: unexpected start bit at cyc %0d, expected idle", idx, cyc);
                    while (txd_w[idx] === 1'b0) @(negedge clk);
                end else begin
                    f       = exp_pop(idx);
                    total   = f.nbits * DIV;
                    bad     = 0;
                    bad_k   = 0;
                    bad_txd = 1'b0; bad_done = 1'b0; bad_busy = 1'b0; exp_b = 1'b0; exp_d = 1'b0;
                    aborted = 1'b0;
                    t0      = cyc;
                    if (idx == 0) start_q.push_back(cyc);
                    for (int k = 0; k < total; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst === 1'b1) begin
                            aborted = 1'b1;
                            $display("frame idx=%0d bits=%03h abandoned by reset at clk %0d", idx, f.bits, k);
                            break;
                        end
                        if (txd_w[idx] !== f.bits[k / DIV] || done_w[idx] !== (k == total - 1) ||
                            busy_w[idx] !== 1'b1) begin
                            if (bad == 0) begin
                                bad_k = k; bad_txd = txd_w[idx]; bad_done = done_w[idx];
                                bad_busy = busy_w[idx]; exp_b = f.bits[k / DIV]; exp_d = (k == total - 1);
                            end
                            bad++;
                        end
                    end
                    if (!aborted) begin
                        n_cmp++;
                        if (bad != 0) begin
                            n_bad++;
                            $display("FAIL frame idx=%0d bits=%03h clk %0d: got txd=%b done=%b busy=%b, expected txd=%b done=%b busy=1",
                                     idx, f.bits, bad_k, bad_txd, bad_done, bad_busy, exp_b, exp_d);
                        end else begin
                            $display("frame idx=%0d bits=%03h len=%0d clks start_cyc=%0d ok", idx, f.bits, total, t0);
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet_bad;
        for (int i = 0; i < 3; i++) begin
            sd[i] = 8'h00;
            sv[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset txd", txd_w[0], 1);
        check("reset tx_busy", busy_w[0], 0);
        check("reset tx_done", done_w[0], 0);
        check("reset fifo_level", level_w[0], 0);
        check("reset s_ready", s_ready_w[0], 0);
        check("reset txd 8o2", txd_w[2], 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1 -> 10'h2AA
        push(0, 8'h55, mk(13'h2AA, 10));
        @(negedge clk);
        check("8n1 txd before pop", txd_w[0], 1);
        check("8n1 level before pop", level_w[0], 1);
        @(negedge clk);
        check("8n1 txd after pop", txd_w[0], 0);
        check("8n1 level after pop", level_w[0], 0);
        check("8n1 busy in frame", busy_w[0], 1);
        repeat (80) @(negedge clk);
        check("8n1 busy after frame", busy_w[0], 0);
        check("8n1 txd after frame", txd_w[0], 1);
        @(posedge clk);
        #1;

        // 8E1 0x07: three ones -> parity 1; bits 1..3, 9, 10 set -> 11'h60E
        push(1, 8'h07, mk(13'h60E, 11));
        // 8O2 0x00: parity 1, two stops -> bits 9..11 -> 12'hE00
        push(2, 8'h00, mk(13'hE00, 12));
        wait_idle(1);
        wait_idle(2);
        @(posedge clk);
        #1;

        // Back to back 0xA1 then 0x3C on consecutive clocks.
        start_q.delete();
        push(0, 8'hA1, f8n1(8'hA1));
        push(0, 8'h3C, f8n1(8'h3C));
        @(negedge clk);
        check("b2b level on pop+push edge", level_w[0], 1);
        wait_idle(0);
        check("b2b start count", start_q.size(), 2);
        if (start_q.size() >= 2) check("b2b start spacing", start_q[1] - start_q[0], 80);
        @(posedge clk);
        #1;

        // Fill: 17 accepted back to back (1 popped, 16 held), 18th waits for first tx_done.
        start_q.delete();
        for (int i = 0; i < 17; i++) begin
            push(0, 8'(i * 37 + 11), f8n1(8'(i * 37 + 11)));
        end
        @(negedge clk);
        check("fill level full", level_w[0], 16);
        check("fill s_ready low", s_ready_w[0], 0);
        @(posedge clk);
        #1;
        push(0, 8'(17 * 37 + 11), f8n1(8'(17 * 37 + 11)));
        check("fill first start recorded", start_q.size() > 0, 1);
        if (start_q.size() > 0) check("fill 18th accept delay", last_push_cyc - start_q[0], 81);
        @(negedge clk);
        check("fill level back to full", level_w[0], 16);
        wait_idle(0);
        @(posedge clk);
        #1;

        // Mid-frame reset at clk 30 with one word still queued.
        push(0, 8'h96, f8n1(8'h96));
        push(0, 8'h5A, f8n1(8'h5A));
        wait_low(0);
        check("rst level before", level_w[0], 1);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        @(negedge clk);
        check("rst txd", txd_w[0], 1);
        check("rst level", level_w[0], 0);
        check("rst busy", busy_w[0], 0);
        check("rst s_ready", s_ready_w[0], 0);
        quiet_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (done_w[0] !== 1'b0 || txd_w[0] !== 1'b1) quiet_bad++;
            @(negedge clk);
        end
        check("rst quiet clocks with done/txd activity", quiet_bad, 0);
        @(posedge clk);
        #1;
        push(0, 8'hC3, f8n1(8'hC3));
        wait_idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
